// File: rtl/apb_node_pkg.sv
// Shared types and helpers for the registered APB 1-to-N node.
// Contents: FSM state enum, default access timeout, port-index width helper.
package apb_node_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

   // Bits needed to hold a port index; never below 1 so single-port builds stay legal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_node_decoder.sv
// Combinational priority window decoder.
// Ports:
//   addr        - address to decode
//   start_addr  - per-port inclusive window start
//   end_addr    - per-port inclusive window end
//   hit         - some window contains addr
//   idx         - lowest-index matching port (0 when no hit)
module apb_node_decoder
   import apb_node_pkg::*;
#(
   parameter int unsigned NB_MASTER      = 8,
   parameter int unsigned APB_ADDR_WIDTH = 32
) (
   input  logic [APB_ADDR_WIDTH-1:0]                 addr,
   input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr,
   input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr,
   output logic                                      hit,
   output logic [idx_width(NB_MASTER)-1:0]           idx
);

   localparam int unsigned IDX_W = idx_width(NB_MASTER);

   // Scan from the top down so the lowest matching index is the last one written.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int k = int'(NB_MASTER) - 1; k >= 0; k--) begin
         if ((addr >= start_addr[k]) && (addr <= end_addr[k])) begin
            hit = 1'b1;
            idx = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/apb_node_reg.sv
// Registered APB 1-to-NB_MASTER node: captures an upstream transfer, decodes it
// against run-time address windows, replays it as SETUP/ACCESS on one downstream
// port and returns a one-cycle registered response. Unmapped addresses get PSLVERR.
// Optional feature macro: APB_NODE_TIMEOUT_EN (abort a stalled ACCESS after
// TIMEOUT_CYCLES cycles with PSLVERR).
// Ports:
//   clk_i, rst_ni                          - clock, async active-low reset
//   psel_i/penable_i/pwrite_i/paddr_i/pwdata_i - upstream request
//   prdata_o/pready_o/pslverr_o            - upstream response (registered)
//   psel_o/penable_o                       - per-port downstream control
//   pwrite_o/paddr_o/pwdata_o              - shared downstream request
//   prdata_i/pready_i/pslverr_i            - per-port downstream response
//   start_addr_i/end_addr_i                - per-port inclusive address windows
module apb_node_reg
   import apb_node_pkg::*;
#(
   parameter int unsigned NB_MASTER      = 8,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic                                      psel_i,
   input  logic                                      penable_i,
   input  logic                                      pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0]                 paddr_i,
   input  logic [APB_DATA_WIDTH-1:0]                 pwdata_i,
   output logic [APB_DATA_WIDTH-1:0]                 prdata_o,
   output logic                                      pready_o,
   output logic                                      pslverr_o,
   output logic [NB_MASTER-1:0]                      psel_o,
   output logic [NB_MASTER-1:0]                      penable_o,
   output logic                                      pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0]                 paddr_o,
   output logic [APB_DATA_WIDTH-1:0]                 pwdata_o,
   input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] prdata_i,
   input  logic [NB_MASTER-1:0]                      pready_i,
   input  logic [NB_MASTER-1:0]                      pslverr_i,
   input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
   input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr_i
);

   localparam int unsigned IDX_W = idx_width(NB_MASTER);

   // Elaboration-time parameter sanity.
   if ((NB_MASTER < 1) || (NB_MASTER > 32) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
      $error("apb_node_reg: NB_MASTER must be 1..32 and TIMEOUT_CYCLES >= 2");
   end

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      pwrite_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_d;
   logic [NB_MASTER-1:0]      psel_d, penable_d;
   logic                      pready_d, pslverr_d;
   logic [APB_DATA_WIDTH-1:0] prdata_d;
   logic                      dec_hit;
   logic [IDX_W-1:0]          dec_idx;

`ifdef APB_NODE_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   apb_node_decoder #(
      .NB_MASTER      (NB_MASTER),
      .APB_ADDR_WIDTH (APB_ADDR_WIDTH)
   ) u_decoder (
      .addr       (paddr_i),
      .start_addr (start_addr_i),
      .end_addr   (end_addr_i),
      .hit        (dec_hit),
      .idx        (dec_idx)
   );

   // Next state, capture values and next output values; outputs follow state_d
   // so every _o port comes straight from a flop.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pwrite_d  = pwrite_o;
      paddr_d   = paddr_o;
      pwdata_d  = pwdata_o;
      prdata_d  = '0;
      pslverr_d = 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (psel_i && !penable_i) begin
               pwrite_d = pwrite_i;
               paddr_d  = paddr_i;
               pwdata_d = pwdata_i;
               idx_d    = dec_idx;
               if (dec_hit) begin
                  state_d = SETUP;
               end else begin
                  state_d   = RESP;
                  pslverr_d = 1'b1;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
`ifdef APB_NODE_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ACCESS: begin
            // A ready in the final timeout cycle still wins.
            if (pready_i[idx_q]) begin
               state_d   = RESP;
               prdata_d  = pwrite_o ? '0 : prdata_i[idx_q];
               pslverr_d = pslverr_i[idx_q];
            end
`ifdef APB_NODE_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d   = RESP;
               pslverr_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      psel_d    = '0;
      penable_d = '0;
      if ((state_d == SETUP) || (state_d == ACCESS)) begin
         psel_d[idx_d] = 1'b1;
      end
      if (state_d == ACCESS) begin
         penable_d[idx_d] = 1'b1;
      end
      pready_d = (state_d == RESP);
   end

   // State, capture and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         pwrite_o  <= 1'b0;
         paddr_o   <= '0;
         pwdata_o  <= '0;
         psel_o    <= '0;
         penable_o <= '0;
         pready_o  <= 1'b0;
         pslverr_o <= 1'b0;
         prdata_o  <= '0;
`ifdef APB_NODE_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pwrite_o  <= pwrite_d;
         paddr_o   <= paddr_d;
         pwdata_o  <= pwdata_d;
         psel_o    <= psel_d;
         penable_o <= penable_d;
         pready_o  <= pready_d;
         pslverr_o <= pslverr_d;
         prdata_o  <= prdata_d;
`ifdef APB_NODE_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_apb_node_reg.sv
// Self-checking bench for apb_node_reg: upstream APB master driver, per-port
// downstream slave model with configurable wait states, and a response scoreboard.
module tb_apb_node_reg;

   localparam int unsigned NB = 8;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic                    clk_i = 1'b0;
   logic                    rst_ni = 1'b0;
   logic                    psel_i, penable_i, pwrite_i;
   logic [AW-1:0]           paddr_i;
   logic [DW-1:0]           pwdata_i;
   logic [DW-1:0]           prdata_o;
   logic                    pready_o, pslverr_o;
   logic [NB-1:0]           psel_o, penable_o;
   logic                    pwrite_o;
   logic [AW-1:0]           paddr_o;
   logic [DW-1:0]           pwdata_o;
   logic [NB-1:0][DW-1:0]   prdata_i;
   logic [NB-1:0]           pready_i, pslverr_i;
   logic [NB-1:0][AW-1:0]   start_addr_i, end_addr_i;

   int unsigned slv_wait [NB];
   int unsigned acc_cnt  [NB];
   logic [32:0] exp_q [$];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   apb_node_reg #(
      .NB_MASTER      (NB),
      .APB_ADDR_WIDTH (AW),
      .APB_DATA_WIDTH (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .psel_i       (psel_i),
      .penable_i    (penable_i),
      .pwrite_i     (pwrite_i),
      .paddr_i      (paddr_i),
      .pwdata_i     (pwdata_i),
      .prdata_o     (prdata_o),
      .pready_o     (pready_o),
      .pslverr_o    (pslverr_o),
      .psel_o       (psel_o),
      .penable_o    (penable_o),
      .pwrite_o     (pwrite_o),
      .paddr_o      (paddr_o),
      .pwdata_o     (pwdata_o),
      .prdata_i     (prdata_i),
      .pready_i     (pready_i),
      .pslverr_i    (pslverr_i),
      .start_addr_i (start_addr_i),
      .end_addr_i   (end_addr_i)
   );

   // Slave model: ready once the port has spent slv_wait ACCESS cycles waiting.
   always_comb begin
      pready_i = '0;
      for (int k = 0; k < int'(NB); k++) begin
         pready_i[k] = psel_o[k] & penable_o[k] & (acc_cnt[k] >= slv_wait[k]);
      end
   end

   always @(posedge clk_i) begin
      for (int k = 0; k < int'(NB); k++) begin
         if (psel_o[k] && penable_o[k] && !pready_i[k]) acc_cnt[k] <= acc_cnt[k] + 1;
         else                                           acc_cnt[k] <= 0;
      end
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One upstream transfer starting at posedge+1; port < 0 means no window should hit.
   task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int port, input logic exp_err,
                       input logic [DW-1:0] exp_rdata, input int exp_lat,
                       input bit drop_mid, input int release_at);
      logic [NB-1:0] mask, seen;
      logic [32:0]   exp;
      int            n;
      mask = (port >= 0) ? (NB'(1) << port) : '0;
      exp_q.push_back({exp_err, exp_rdata});
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = wdata;
      @(posedge clk_i); #1;
      n    = 1;
      seen = psel_o;
      if (port >= 0) begin
         check_eq({tag, "_t1_sel"}, psel_o, mask);
         check_eq({tag, "_t1_en"}, penable_o, '0);
         check_eq({tag, "_bus"}, {pwrite_o, paddr_o, pwdata_o}, {wr, addr, wdata});
      end
      if (drop_mid) begin
         psel_i = 1'b0; penable_i = 1'b0;
      end else begin
         penable_i = 1'b1;
      end
      while (!pready_o && n < 3000) begin
         @(posedge clk_i); #1;
         n++;
         seen |= psel_o;
         if (n == 2 && port >= 0) check_eq({tag, "_t2_en"}, penable_o, mask);
         if (n == release_at && port >= 0) begin
            check_eq({tag, "_pending"}, {pready_o, |(penable_o & mask)}, 2'b01);
            slv_wait[port] = 0;
         end
      end
      check_eq({tag, "_pready"}, pready_o, 1'b1);
      if (exp_lat > 0) check_eq({tag, "_lat"}, n, exp_lat);
      check_eq({tag, "_sel_seen"}, seen, mask);
      check_eq({tag, "_resp_idle"}, {psel_o, penable_o}, '0);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         if (pready_o) begin
            check_eq({tag, "_rdata"}, prdata_o, exp[31:0]);
            check_eq({tag, "_err"}, pslverr_o, exp[32]);
         end
      end
      @(posedge clk_i); #1;
      check_eq({tag, "_one_cycle"}, pready_o, 1'b0);
      psel_i = 1'b0; penable_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]    p;
      logic          wr, seen_rdy;
      logic [DW-1:0] d;
      logic [11:0]   off;

      psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0; pwdata_i = '0;
      pslverr_i = '0;
      for (int k = 0; k < int'(NB); k++) begin
         start_addr_i[k] = 32'h1A10_0000 + 32'(k) * 32'h1000;
         end_addr_i[k]   = 32'h1A10_0FFF + 32'(k) * 32'h1000;
         prdata_i[k]     = 32'hD000_0000 | 32'(k);
         slv_wait[k]     = 0;
      end
      prdata_i[0] = 32'h1234_5678;
      slv_wait[0] = 4;

      repeat (3) @(posedge clk_i);
      #1;
      check_eq("rst_ctrl", {psel_o, penable_o, pwrite_o, pready_o, pslverr_o}, '0);
      check_eq("rst_data", {paddr_o, pwdata_o, prdata_o}, '0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      xfer("wr_p3",      1'b1, 32'h1A10_3004, 32'hA5A5_0001,  3, 1'b0, 32'h0,          3, 1'b0, 0);
      xfer("rd_p0_ws4",  1'b0, 32'h1A10_0010, 32'h0,          0, 1'b0, 32'h1234_5678,  7, 1'b0, 0);
      xfer("miss_hi",    1'b0, 32'hFFFF_0000, 32'h0,         -1, 1'b1, 32'h0,          1, 1'b0, 0);
      xfer("rd_p7_end",  1'b0, 32'h1A10_7FFF, 32'h0,          7, 1'b0, 32'hD000_0007,  3, 1'b0, 0);
      xfer("miss_lo",    1'b1, 32'h1A0F_FFFF, 32'hDEAD_BEEF, -1, 1'b1, 32'h0,          1, 1'b0, 0);
      slv_wait[0] = 0;
      xfer("rd_p0_start", 1'b0, 32'h1A10_0000, 32'h0,         0, 1'b0, 32'h1234_5678,  3, 1'b0, 0);

      // Port 5 window widened to cover ports 2..5.
      start_addr_i[5] = 32'h1A10_2000;
      xfer("ovl_p2",     1'b0, 32'h1A10_2800, 32'h0,          2, 1'b0, 32'hD000_0002,  3, 1'b0, 0);
      xfer("ovl_p4",     1'b1, 32'h1A10_4800, 32'h0BAD_F00D,  4, 1'b0, 32'h0,          3, 1'b0, 0);
      start_addr_i[5] = 32'h1A10_5000;

      pslverr_i[6] = 1'b1;
      xfer("err_rd_p6",  1'b0, 32'h1A10_6100, 32'h0,          6, 1'b1, 32'hD000_0006,  3, 1'b0, 0);
      xfer("err_wr_p6",  1'b1, 32'h1A10_6104, 32'h5555_AAAA,  6, 1'b1, 32'h0,          3, 1'b0, 0);
      pslverr_i[6] = 1'b0;

      xfer("drop_p1",    1'b0, 32'h1A10_1008, 32'h0,          1, 1'b0, 32'hD000_0001,  3, 1'b1, 0);

      slv_wait[4] = 1000000;
`ifdef APB_NODE_TIMEOUT_EN
      xfer("timeout_p4", 1'b0, 32'h1A10_4020, 32'h0,          4, 1'b1, 32'h0,         10, 1'b0, 0);
      slv_wait[4] = 0;
`else
      xfer("stall_p4",   1'b0, 32'h1A10_4020, 32'h0,          4, 1'b0, 32'hD000_0004,  0, 1'b0, 1000);
`endif

      // Reset in the middle of ACCESS.
      slv_wait[1] = 1000000;
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h1A10_1010;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      @(posedge clk_i); #1;
      check_eq("rst_mid_access", {psel_o, penable_o}, {8'h02, 8'h02});
      #2 rst_ni = 1'b0;
      #1;
      check_eq("rst_mid_ctrl", {psel_o, penable_o, pready_o, pslverr_o, prdata_o}, '0);
      check_eq("rst_mid_bus", {pwrite_o, paddr_o, pwdata_o}, '0);
      psel_i = 1'b0; penable_i = 1'b0;
      seen_rdy = 1'b0;
      repeat (3) begin
         @(posedge clk_i); #1;
         seen_rdy |= pready_o;
      end
      check_eq("rst_no_resp", seen_rdy, 1'b0);
      rst_ni = 1'b1;
      slv_wait[1] = 0;
      @(posedge clk_i); #1;
      xfer("post_rst",   1'b0, 32'h1A10_1010, 32'h0,          1, 1'b0, 32'hD000_0001,  3, 1'b0, 0);

      for (int i = 0; i < 8; i++) begin
         p   = 3'($urandom_range(0, 7));
         wr  = 1'($urandom_range(0, 1));
         d   = $urandom;
         off = 12'($urandom_range(0, 4095));
         xfer("rnd", wr, 32'h1A10_0000 + 32'(p) * 32'h1000 + 32'(off), d, int'(p), 1'b0,
              wr ? 32'h0 : prdata_i[p], 3, 1'b0, 0);
      end

      check_eq("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
